// File: rtl/sm83_mem_responder.sv
// SM83 memory-side responder: ROM pass-through, WRAM with echo, HRAM,
// serial port (SB/SC) feeding a debug byte FIFO, and IF/IE interrupt registers.
// Reads are registered with one cycle of latency and see pre-write contents.
module sm83_mem_responder #(
   parameter int DBG_DEPTH = 4,
   parameter int WRAM_AW   = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] r_addr,
   input  logic [15:0] w_addr,
   input  logic [7:0]  w_data,
   input  logic        w_wen,
   output logic [7:0]  r_data,
   output logic [14:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        dbg_valid,
   output logic [7:0]  dbg_data,
   input  logic        dbg_ready,
   output logic        dbg_overflow,
   output logic        irq_req
);

   localparam int PW = $clog2(DBG_DEPTH);
   localparam int CW = PW + 1;

   // Storage arrays (never reset; contents undefined at power-up)
   logic [7:0] wram_q [0:(2**WRAM_AW)-1];
   logic [7:0] hram_q [0:126];
   logic [7:0] fifo_q [0:DBG_DEPTH-1];

   // Control state
   logic [7:0]    r_data_q, r_data_d;
   logic [7:0]    sb_q, sb_d;
   logic          sc7_q, sc7_d, sc0_q, sc0_d;
   logic          busy_q, busy_d;
   logic [4:0]    if_q, if_d;
   logic [7:0]    ie_q, ie_d;
   logic          irq_q, irq_d;
   logic          ovf_q, ovf_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Address decode
   logic rd_rom_s, rd_wram_s, rd_hram_s;
   logic wr_wram_s, wr_hram_s, wr_sb_s, wr_sc_s, wr_if_s, wr_ie_s;
   logic start_s, pop_s, full_s, push_s, drop_s;

   assign rom_addr  = r_addr[14:0];
   assign rd_rom_s  = (r_addr[15] == 1'b0);
   assign rd_wram_s = (r_addr >= 16'hC000) && (r_addr <= 16'hFDFF);
   assign rd_hram_s = (r_addr >= 16'hFF80) && (r_addr <= 16'hFFFE);
   assign wr_wram_s = w_wen && (w_addr >= 16'hC000) && (w_addr <= 16'hFDFF);
   assign wr_hram_s = w_wen && (w_addr >= 16'hFF80) && (w_addr <= 16'hFFFE);
   assign wr_sb_s   = w_wen && (w_addr == 16'hFF01);
   assign wr_sc_s   = w_wen && (w_addr == 16'hFF02);
   assign wr_if_s   = w_wen && (w_addr == 16'hFF0F);
   assign wr_ie_s   = w_wen && (w_addr == 16'hFFFF);

   // Internal-clock transfer start pushes the current (pre-write) SB byte
   assign start_s = wr_sc_s && w_data[7] && w_data[0];
   assign pop_s   = (cnt_q != {CW{1'b0}}) && dbg_ready;
   assign full_s  = (cnt_q == CW'(DBG_DEPTH));
   assign push_s  = start_s && (!full_s || pop_s);
   assign drop_s  = start_s && full_s && !pop_s;

   assign r_data       = r_data_q;
   assign dbg_valid    = (cnt_q != {CW{1'b0}});
   assign dbg_data     = fifo_q[rd_ptr_q];
   assign dbg_overflow = ovf_q;
   assign irq_req      = irq_q;

   // Read mux: selects the pre-write value of the addressed location
   always_comb begin
      r_data_d = 8'hFF;
      if (rd_rom_s) begin
         r_data_d = rom_data;
      end else if (rd_wram_s) begin
         r_data_d = wram_q[r_addr[WRAM_AW-1:0]];
      end else if (rd_hram_s) begin
         r_data_d = hram_q[r_addr[6:0]];
      end else begin
         case (r_addr)
            16'hFF01: r_data_d = sb_q;
            16'hFF02: r_data_d = {sc7_q, 6'b111111, sc0_q};
            16'hFF0F: r_data_d = {3'b111, if_q};
            16'hFFFF: r_data_d = ie_q;
            default:  r_data_d = 8'hFF;
         endcase
      end
   end

   // Register next-state: CPU writes, transfer completion, FIFO bookkeeping
   always_comb begin
      sb_d     = sb_q;
      sc7_d    = sc7_q;
      sc0_d    = sc0_q;
      if_d     = if_q;
      ie_d     = ie_q;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      busy_d   = start_s;

      if (wr_sb_s) sb_d = w_data;
      else         sb_d = sb_q;

      if (wr_sc_s) begin
         sc7_d = w_data[7];
         sc0_d = w_data[0];
      end else begin
         sc7_d = sc7_q;
         sc0_d = sc0_q;
      end

      if (wr_if_s) if_d = w_data[4:0];
      else         if_d = if_q;

      // Completion of the one-cycle busy period beats a same-cycle CPU write
      if (busy_q) begin
         if_d[3] = 1'b1;
         if (!start_s) sc7_d = 1'b0;
         else          sc7_d = 1'b1;
      end else begin
         if_d[3] = if_d[3];
      end

      if (wr_ie_s) ie_d = w_data;
      else         ie_d = ie_q;

      if (drop_s) ovf_d = 1'b1;
      else        ovf_d = ovf_q;

      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;

      if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1);
      else       rd_ptr_d = rd_ptr_q;

      cnt_d = cnt_q + CW'(push_s) - CW'(pop_s);
      irq_d = |(ie_d[4:0] & if_d);
   end

   // Control/status registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_q <= 8'hFF;
         sb_q     <= 8'h00;
         sc7_q    <= 1'b0;
         sc0_q    <= 1'b0;
         busy_q   <= 1'b0;
         if_q     <= 5'h00;
         ie_q     <= 8'h00;
         irq_q    <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         r_data_q <= r_data_d;
         sb_q     <= sb_d;
         sc7_q    <= sc7_d;
         sc0_q    <= sc0_d;
         busy_q   <= busy_d;
         if_q     <= if_d;
         ie_q     <= ie_d;
         irq_q    <= irq_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // RAM and FIFO storage writes (no reset on data arrays)
   always_ff @(posedge clk) begin
      if (wr_wram_s) wram_q[w_addr[WRAM_AW-1:0]] <= w_data;
      if (wr_hram_s) hram_q[w_addr[6:0]] <= w_data;
      if (push_s)    fifo_q[wr_ptr_q] <= sb_q;
   end

endmodule

// File: doc/sm83_mem_responder.md
SM83_MEM_RESPONDER -- requirements
Module: sm83_mem_responder

Interface
REQ-001 Parameter DBG_DEPTH, default 4, debug-byte FIFO depth (power of two, >=2).
REQ-002 Parameter WRAM_AW, default 13, WRAM address width (8 KiB).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 r_addr  input  16  CPU read address.
REQ-006 w_addr  input  16  CPU write address.
REQ-007 w_data  input  8  CPU write data.
REQ-008 w_wen  input  1  CPU write strobe, one write per cycle asserted.
REQ-009 r_data  output  8  registered read data returned to CPU.
REQ-010 rom_addr  output  15  external ROM address.
REQ-011 rom_data  input  8  external ROM data, combinational from rom_addr.
REQ-012 dbg_valid  output  1  debug FIFO non-empty.
REQ-013 dbg_data  output  8  debug FIFO head byte.
REQ-014 dbg_ready  input  1  consumer accepts head when dbg_valid & dbg_ready.
REQ-015 dbg_overflow  output  1  sticky: a debug byte was dropped.
REQ-016 irq_req  output  1  (IE & IF & 0x1F) != 0.

Function
REQ-017 Address map: 0000-7FFF ROM; C000-DFFF WRAM; E000-FDFF echo of C000-DDFF; FF01 SB; FF02 SC; FF0F IF; FF80-FFFE HRAM (127 B); FFFF IE; all else unmapped.
REQ-018 Read latency exactly 1 cycle: r_data at cycle N+1 reflects the location addressed by r_addr at edge N.
REQ-019 rom_addr = r_addr[14:0] combinationally; rom_data captured into r_data at the edge when r_addr is in ROM.
REQ-020 Unmapped reads return 0xFF; unmapped and ROM-range writes are ignored, no side effects.
REQ-021 Same-address read and write in one cycle: r_data returns pre-write value (read-before-write).
REQ-022 SB: 8-bit R/W. SC reads {sc7, 6'b111111, sc0}; writes set sc7=w_data[7], sc0=w_data[0].
REQ-023 Write to SC with w_data[7]=1 and w_data[0]=1 starts a transfer: SB byte pushed into debug FIFO that edge; sc7 cleared and IF[3] set on the following edge (1-cycle busy).
REQ-024 Transfer start with FIFO full: byte dropped, dbg_overflow set, sc7/IF[3] completion still occur.
REQ-025 SC write with w_data[7]=1, w_data[0]=0 (external clock): sc7 held set, no push, no completion.
REQ-026 SB write during busy cycle updates SB; pushed byte is the pre-write SB value.
REQ-027 IF: bits[4:0] R/W, bits[7:5] read as 1. IF[3] set by completion wins over a same-cycle CPU write clearing IF[3].
REQ-028 IE: full 8-bit R/W.
REQ-029 FIFO: dbg_data = head, dbg_valid = count!=0; pop on dbg_valid & dbg_ready; push and pop in same cycle when full succeed (no drop, count unchanged); pointers wrap modulo DBG_DEPTH.
REQ-030 dbg_overflow cleared only by reset.
REQ-031 WRAM/HRAM contents undefined after power-up and not cleared by reset.

Reset
REQ-032 On rst_n low: r_data=0xFF, SB=0x00, sc7=0, sc0=0, IF[4:0]=0, IE=0x00, FIFO empty (dbg_valid=0), dbg_overflow=0, irq_req=0, busy cleared.
REQ-033 Reset asserted mid-transfer abandons completion; no IF[3] set after release.
REQ-034 First read after rst_n deassert follows REQ-018 latency.

Verification
REQ-035 Write 0x5A to C123, then read E123 -> r_data=0x5A one cycle after address; read FF7F -> 0xFF.
REQ-036 Write 0x41 to FF01, 0x81 to FF02, dbg_ready=1 -> dbg_valid with dbg_data=0x41; FF02 reads 0x7F two cycles after write; FF0F reads 0xE8.
REQ-037 dbg_ready=0, five transfers with DBG_DEPTH=4 (bytes 01..05) -> dbg_overflow=1, then drain yields 01,02,03,04.
REQ-038 IE=0x08 then transfer -> irq_req=1; write FF0F=0x00 -> irq_req=0.
REQ-039 Same cycle: write 0x77 to FF90 while reading FF90 holding 0x11 -> r_data=0x11, next read returns 0x77.
REQ-040 rom_data=0xC3 with r_addr=0x0100 -> rom_addr=0x0100, r_data=0xC3 next cycle; write to 0x2000 leaves all state unchanged.
